// File: rtl/btn_toggle_pulser_if.sv
// Button-side signal bundle for btn_toggle_pulser: raw button in, conditioned pulse/level out.
interface btn_toggle_pulser_if;
    logic btn_in;
    logic t_pulse;
    logic btn_level;
    logic repeating;

    modport master (output btn_in, input t_pulse, input btn_level, input repeating);
    modport slave  (input btn_in, output t_pulse, output btn_level, output repeating);
endinterface

// File: rtl/btn_toggle_pulser.sv
// Raw push-button -> synchronizer -> debounce FSM -> one-cycle toggle pulse,
// with optional auto-repeat while the button stays held.
module btn_toggle_pulser #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_toggle_pulser_if.slave   bus
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   t_pulse_q, t_pulse_d;
    logic                   btn_level_q, btn_level_d;
    logic                   repeating_q, repeating_d;
    logic                   btn_sync;
    logic                   rpt_hit;

    assign btn_sync = sync_q[SYNC_STAGES-1];
    // rcnt is reloaded to 0 on every hit, so it never exceeds the active limit
    assign rpt_hit  = (REPEAT_EN != 0) && (rcnt_q == (repeating_q ? PERIOD_LAST : DELAY_LAST));

    assign bus.t_pulse   = t_pulse_q;
    assign bus.btn_level = btn_level_q;
    assign bus.repeating = repeating_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            t_pulse_q   <= t_pulse_d;
            btn_level_q <= btn_level_d;
            repeating_q <= repeating_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (btn_sync) state_d = (DEBOUNCE_CYCLES == 1) ? HELD : DB_PRESS;
            DB_PRESS:   if (!btn_sync) state_d = IDLE;
                        else if (dcnt_q == DB_LAST) state_d = HELD;
            HELD:       if (!btn_sync) state_d = (DEBOUNCE_CYCLES == 1) ? IDLE : DB_RELEASE;
            DB_RELEASE: if (btn_sync) state_d = HELD;
                        else if (dcnt_q == DB_LAST) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        t_pulse_d   = 1'b0;
        btn_level_d = btn_level_q;
        repeating_d = repeating_q;
        unique case (state_q)
            IDLE: begin
                dcnt_d = '0;
                if (btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        t_pulse_d   = 1'b1;
                        btn_level_d = 1'b1;
                        rcnt_d      = '0;
                    end else begin
                        dcnt_d = DW'(1);
                    end
                end
            end
            DB_PRESS: begin
                if (!btn_sync) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DB_LAST) begin
                    t_pulse_d   = 1'b1;
                    btn_level_d = 1'b1;
                    rcnt_d      = '0;
                    dcnt_d      = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        btn_level_d = 1'b0;
                        repeating_d = 1'b0;
                        dcnt_d      = '0;
                    end else begin
                        dcnt_d = DW'(1);
                    end
                end else if (REPEAT_EN != 0) begin
                    if (rpt_hit) begin
                        t_pulse_d   = 1'b1;
                        repeating_d = 1'b1;
                        rcnt_d      = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            DB_RELEASE: begin
                // rcnt is frozen here; a bounce back to HELD restarts the repeat schedule
                if (btn_sync) begin
                    rcnt_d      = '0;
                    repeating_d = 1'b0;
                    dcnt_d      = '0;
                end else if (dcnt_q == DB_LAST) begin
                    btn_level_d = 1'b0;
                    repeating_d = 1'b0;
                    dcnt_d      = '0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                dcnt_d = '0;
                rcnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_toggle_pulser.sv
// Directed bench for btn_toggle_pulser: three configurations driven from one linear sequence.
module tb_btn_toggle_pulser;

    logic clk;
    logic reset;
    logic q_c;
    int   vectors;
    int   errors;

    btn_toggle_pulser_if ifa ();
    btn_toggle_pulser_if ifb ();
    btn_toggle_pulser_if ifc ();

    btn_toggle_pulser #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                        .REPEAT_DELAY(16), .REPEAT_PERIOD(8))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));

    btn_toggle_pulser #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                        .REPEAT_DELAY(16), .REPEAT_PERIOD(8))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    btn_toggle_pulser #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .REPEAT_EN(0),
                        .REPEAT_DELAY(16), .REPEAT_PERIOD(8))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    // Downstream T flip-flop fed by dut_c
    always @(posedge clk or posedge reset) begin
        if (reset)            q_c <= 1'b0;
        else if (ifc.t_pulse) q_c <= ~q_c;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        ifa.btn_in = 1'b0;
        ifb.btn_in = 1'b0;
        ifc.btn_in = 1'b0;
        repeat (3) tick();
        chk("rst_a_pulse", 0, ifa.t_pulse, 1'b0);
        chk("rst_a_level", 0, ifa.btn_level, 1'b0);
        chk("rst_a_rep",   0, ifa.repeating, 1'b0);
        chk("rst_b_pulse", 0, ifb.t_pulse, 1'b0);
        chk("rst_b_level", 0, ifb.btn_level, 1'b0);
        chk("rst_b_rep",   0, ifb.repeating, 1'b0);
        chk("rst_c_pulse", 0, ifc.t_pulse, 1'b0);
        chk("rst_c_level", 0, ifc.btn_level, 1'b0);
        chk("rst_c_q",     0, q_c, 1'b0);
        reset = 1'b0;

        // Single press, no repeat: pulse after edge 6, level falls 6 edges after release
        ifa.btn_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("t1_pulse", k, ifa.t_pulse, k == 6);
            chk("t1_level", k, ifa.btn_level, k >= 6);
            chk("t1_rep",   k, ifa.repeating, 1'b0);
        end
        ifa.btn_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t1r_pulse", k, ifa.t_pulse, 1'b0);
            chk("t1r_level", k, ifa.btn_level, k < 6);
        end

        // Bounce rejection
        for (int k = 1; k <= 16; k++) begin
            ifa.btn_in = (k <= 8) && (k % 2 == 1);
            tick();
            chk("t2_pulse", k, ifa.t_pulse, 1'b0);
            chk("t2_level", k, ifa.btn_level, 1'b0);
        end
        ifa.btn_in = 1'b0;

        // Auto-repeat, then a 2-cycle release bounce from edge 64
        ifb.btn_in = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            tick();
            chk("t3_pulse", k, ifb.t_pulse,
                (k == 6) || (k >= 22 && k <= 62 && (k - 22) % 8 == 0) || k == 85 || k == 93);
            chk("t3_level", k, ifb.btn_level, k >= 6);
            chk("t3_rep",   k, ifb.repeating, (k >= 22 && k < 69) || k >= 85);
            if (k == 64) ifb.btn_in = 1'b0;
            if (k == 66) ifb.btn_in = 1'b1;
        end

        // Asynchronous reset mid-repeat, button still held
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_pulse", 0, ifb.t_pulse, 1'b0);
        chk("t5_async_level", 0, ifb.btn_level, 1'b0);
        chk("t5_async_rep",   0, ifb.repeating, 1'b0);
        tick();
        chk("t5_hold_level", 0, ifb.btn_level, 1'b0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t5_pulse", k, ifb.t_pulse, k == 6);
            chk("t5_level", k, ifb.btn_level, k >= 6);
            chk("t5_rep",   k, ifb.repeating, 1'b0);
        end
        ifb.btn_in = 1'b0;
        repeat (10) tick();

        // DEBOUNCE_CYCLES=1, SYNC_STAGES=3 driving a T flip-flop
        ifc.btn_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6_pulse", k, ifc.t_pulse, k == 4);
            chk("t6_level", k, ifc.btn_level, k >= 4);
            chk("t6_q",     k, q_c, k >= 5);
        end
        ifc.btn_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t6r_pulse", k, ifc.t_pulse, 1'b0);
            chk("t6r_level", k, ifc.btn_level, k < 4);
            chk("t6r_q",     k, q_c, 1'b1);
        end
        ifc.btn_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6b_pulse", k, ifc.t_pulse, k == 4);
            chk("t6b_q",     k, q_c, k < 5);
        end
        ifc.btn_in = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
